// File: rtl/acs_regex_core.sv
// acs_regex_core: 4-state rate-1/2 Viterbi add-compare-select core with register-exchange survivors.
// Define ACS_SOFT_EN for soft-decision branch metrics on 2*SOFT_W-bit samples; hard Hamming metric otherwise.
module acs_regex_core #(
    parameter int PM_W       = 8,
    parameter int SURV_DEPTH = 8,
    parameter int INIT_PM    = 16,
    parameter int SOFT_W     = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            in_valid,
`ifdef ACS_SOFT_EN
    input  logic [2*SOFT_W-1:0] data_recv,
`else
    input  logic [1:0]      data_recv,
`endif
    output logic            dec_valid,
    output logic            dec_bit,
    output logic [PM_W-1:0] best_pm
);
`ifdef ACS_SOFT_EN
    localparam int BM_W = SOFT_W + 1;
    localparam int DW   = 2 * SOFT_W;
`else
    localparam int BM_W = 2;
    localparam int DW   = 2;
`endif
    localparam int FW = $clog2(SURV_DEPTH);
    localparam logic [FW-1:0] LAST = FW'(SURV_DEPTH - 1);

    if (PM_W < 5 || SURV_DEPTH < 2 || SOFT_W < 1) begin : g_bad_params
        $error("acs_regex_core: illegal parameter values");
    end

    function automatic logic [1:0] exp_sym(input logic [1:0] p, input logic u);
        return {u ^ p[1] ^ p[0], u ^ p[0]};
    endfunction

    function automatic logic [BM_W-1:0] branch(input logic [1:0] e, input logic [DW-1:0] d);
`ifdef ACS_SOFT_EN
        logic [SOFT_W-1:0] c1 = e[1] ? ~d[DW-1:SOFT_W] : d[DW-1:SOFT_W];
        logic [SOFT_W-1:0] c0 = e[0] ? ~d[SOFT_W-1:0] : d[SOFT_W-1:0];
        return {1'b0, c1} + {1'b0, c0};
`else
        return {1'b0, e[1] ^ d[1]} + {1'b0, e[0] ^ d[0]};
`endif
    endfunction

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm_v, input logic [BM_W-1:0] bm);
        logic [PM_W:0] s = {1'b0, pm_v} + (PM_W+1)'(bm);
        return s[PM_W] ? '1 : s[PM_W-1:0];
    endfunction

    logic [PM_W-1:0]       pm      [4];
    logic [PM_W-1:0]       pm_in   [4];
    logic [PM_W-1:0]       pm_raw  [4];
    logic [PM_W-1:0]       pm_nx   [4];
    logic [SURV_DEPTH-2:0] surv    [4];
    logic [SURV_DEPTH-1:0] surv_nx [4];
    logic [FW-1:0]         fill;
    logic                  norm;
    logic                  dv_nx;
    logic [1:0]            best;

    for (genvar i = 0; i < 4; i++) begin : g_acs
        localparam logic [1:0] S  = 2'(i);
        localparam logic [1:0] PA = {S[0], 1'b0};
        localparam logic [1:0] PB = {S[0], 1'b1};
        logic [BM_W-1:0]       bm_a, bm_b;
        logic [PM_W-1:0]       c_a, c_b;
        logic                  sel;
        logic [SURV_DEPTH-2:0] prev;
        assign pm_in[i]   = frame_start ? (i == 0 ? '0 : PM_W'(INIT_PM)) : pm[i];
        assign bm_a       = branch(exp_sym(PA, S[1]), data_recv);
        assign bm_b       = branch(exp_sym(PB, S[1]), data_recv);
        assign c_a        = sat_add(pm_in[PA], bm_a);
        assign c_b        = sat_add(pm_in[PB], bm_b);
        // equal sums resolve toward the branch with the smaller metric, pB when those tie too
        assign sel        = c_a > c_b || (c_a == c_b && bm_a >= bm_b);
        assign pm_raw[i]  = sel ? c_b : c_a;
        assign prev       = frame_start ? '0 : surv[sel ? PB : PA];
        assign surv_nx[i] = {prev, S[1]};
        assign pm_nx[i]   = norm ? {1'b0, pm_raw[i][PM_W-2:0]} : pm_raw[i];
    end

    assign norm  = pm_raw[0][PM_W-1] & pm_raw[1][PM_W-1] & pm_raw[2][PM_W-1] & pm_raw[3][PM_W-1];
    assign dv_nx = !frame_start && fill == LAST;

    always_comb begin
        best = 2'd0;
        for (int k = 1; k < 4; k++)
            if (pm_nx[k] < pm_nx[best]) best = 2'(k);
    end

    // the oldest survivor bit is consumed straight from surv_nx, so only SURV_DEPTH-1 bits are stored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                pm[k]   <= k == 0 ? '0 : PM_W'(INIT_PM);
                surv[k] <= '0;
            end
            fill      <= '0;
            dec_valid <= 1'b0;
            dec_bit   <= 1'b0;
            best_pm   <= '0;
        end else if (in_valid) begin
            for (int k = 0; k < 4; k++) begin
                pm[k]   <= pm_nx[k];
                surv[k] <= surv_nx[k][SURV_DEPTH-2:0];
            end
            fill      <= frame_start ? FW'(1) : fill + FW'(fill != LAST);
            dec_valid <= dv_nx;
            dec_bit   <= dv_nx ? surv_nx[best][SURV_DEPTH-1] : dec_bit;
            best_pm   <= pm_nx[best];
        end else begin
            dec_valid <= 1'b0;
            if (frame_start) begin
                for (int k = 0; k < 4; k++) begin
                    pm[k]   <= pm_in[k];
                    surv[k] <= '0;
                end
                fill <= '0;
            end
        end
    end
endmodule

// File: tb/tb_acs_regex_core.sv
// tb_acs_regex_core: scoreboard bench running a default core and a PM_W=6 core on a shared stream.
module tb_acs_regex_core;
    localparam int SD = 8;
`ifdef ACS_SOFT_EN
    localparam int DW   = 6;
    localparam int UNIT = 7;
`else
    localparam int DW   = 2;
    localparam int UNIT = 1;
`endif

    logic          clk = 0, rst = 0, frame_start = 0, in_valid = 0;
    logic [DW-1:0] data_recv = '0;
    logic          dv8, db8, dv6, db6;
    logic [7:0]    bp8;
    logic [5:0]    bp6;

    always #5 clk = ~clk;

    acs_regex_core u8 (.clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
        .data_recv(data_recv), .dec_valid(dv8), .dec_bit(db8), .best_pm(bp8));
    acs_regex_core #(.PM_W(6)) u6 (.clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
        .data_recv(data_recv), .dec_valid(dv6), .dec_bit(db6), .best_pm(bp6));

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // expected symbol per new state: [s][0] from pA, [s][1] from pB
    logic [1:0] exp_tab [4][2] = '{'{2'b00, 2'b11}, '{2'b10, 2'b01}, '{2'b11, 2'b00}, '{2'b01, 2'b10}};

    function automatic logic [DW-1:0] sym(input logic [1:0] c);
`ifdef ACS_SOFT_EN
        return {c[1] ? 3'd7 : 3'd0, c[0] ? 3'd7 : 3'd0};
`else
        return c;
`endif
    endfunction

    function automatic int bmet(input logic [DW-1:0] d, input logic [1:0] e);
`ifdef ACS_SOFT_EN
        int r1 = int'(d[5:3]);
        int r0 = int'(d[2:0]);
        return (e[1] ? 7 - r1 : r1) + (e[0] ? 7 - r0 : r0);
`else
        return int'(d[1] != e[1]) + int'(d[0] != e[0]);
`endif
    endfunction

    int            mpm  [2][4];
    logic [SD-1:0] msv  [2][4];
    int            mfill[2];
    logic          mdb  [2];
    int            mbest[2];

    typedef struct {int k; logic dv; logic db; int pm;} exp_t;
    exp_t sb[$];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 4; s++) begin
                mpm[k][s] = s == 0 ? 0 : 16;
                msv[k][s] = '0;
            end
            mfill[k] = 0;
            mdb[k]   = 1'b0;
            mbest[k] = 0;
        end
    endtask

    task automatic model_step(input logic fs, input logic v, input logic [DW-1:0] d);
        for (int k = 0; k < 2; k++) begin
            int            w, top, half, b;
            int            bp [4];
            int            npm[4];
            logic [SD-1:0] bs [4];
            logic [SD-1:0] nsv[4];
            logic          dvx;
            w    = k == 0 ? 8 : 6;
            top  = (1 << w) - 1;
            half = 1 << (w - 1);
            dvx  = 1'b0;
            for (int s = 0; s < 4; s++) begin
                bp[s] = fs ? (s == 0 ? 0 : 16) : mpm[k][s];
                bs[s] = fs ? '0 : msv[k][s];
            end
            if (v) begin
                for (int s = 0; s < 4; s++) begin
                    int pa, pb, ba, bb, ca, cb, p;
                    logic pick;
                    pa = 2 * (s % 2);
                    pb = pa + 1;
                    ba = bmet(d, exp_tab[s][0]);
                    bb = bmet(d, exp_tab[s][1]);
                    ca = bp[pa] + ba > top ? top : bp[pa] + ba;
                    cb = bp[pb] + bb > top ? top : bp[pb] + bb;
                    pick = cb < ca || (cb == ca && !(ba < bb));
                    p = pick ? pb : pa;
                    npm[s] = pick ? cb : ca;
                    nsv[s] = {bs[p][SD-2:0], 1'(s / 2)};
                end
                if (npm[0] >= half && npm[1] >= half && npm[2] >= half && npm[3] >= half)
                    for (int s = 0; s < 4; s++) npm[s] -= half;
                b = 0;
                for (int s = 1; s < 4; s++) if (npm[s] < npm[b]) b = s;
                dvx = !fs && mfill[k] == SD - 1;
                if (dvx) mdb[k] = nsv[b][SD-1];
                mfill[k] = fs ? 1 : (mfill[k] == SD - 1 ? SD - 1 : mfill[k] + 1);
                mbest[k] = npm[b];
                mpm[k] = npm;
                msv[k] = nsv;
            end else if (fs) begin
                mpm[k]   = bp;
                msv[k]   = bs;
                mfill[k] = 0;
            end
            sb.push_back('{k, dvx, mdb[k], mbest[k]});
        end
    endtask

    task automatic step(input logic fs, input logic v, input logic [DW-1:0] d);
        frame_start = fs;
        in_valid    = v;
        data_recv   = d;
        model_step(fs, v, d);
        @(posedge clk);
        #1;
        frame_start = 0;
        in_valid    = 0;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            if (e.k == 0) begin
                chk("dv8", 32'(dv8), 32'(e.dv));
                chk("db8", 32'(db8), 32'(e.db));
                chk("pm8", 32'(bp8), e.pm);
            end else begin
                chk("dv6", 32'(dv6), 32'(e.dv));
                chk("db6", 32'(db6), 32'(e.db));
                chk("pm6", 32'(bp6), e.pm);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nv, nz, first, drops, prev;
        logic [4:0] got;
        logic [1:0] c, s;
        logic u, u1, u2;
        logic [11:0] ubits;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dv", 32'(dv8), 0);
        chk("rst_db", 32'(db8), 0);
        chk("rst_pm", 32'(bp8), 0);
        rst = 1;

        // frame start then 20 all-zero symbols
        step(1, 0, sym(2'b00));
        nv = 0; nz = 0; first = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, sym(2'b00));
            if (dv8) begin
                nv++;
                if (!db8) nz++;
                if (first == 0) first = i;
            end
        end
        chk("zero_first", first, 8);
        chk("zero_valid_cnt", nv, 13);
        chk("zero_bit_cnt", nz, 13);
        chk("zero_pm", 32'(bp8), 0);

        // encoded 1,0,1,1,0,0... with one code bit flipped in symbol 3
        ubits = 12'b0000_0000_1101;
        u1 = 0; u2 = 0; nv = 0; got = '0;
        for (int i = 0; i < 12; i++) begin
            u = ubits[i];
            s = {u, u1};
            c = exp_tab[s][u2];
            if (i == 2) c ^= 2'b01;
            step(i == 0, 1, sym(c));
            if (dv8) begin
                if (nv < 5) got[nv] = db8;
                nv++;
            end
            u2 = u1;
            u1 = u;
        end
        chk("enc_cnt", nv, 5);
        for (int i = 0; i < 5; i++) chk("enc_bit", 32'(got[i]), 32'(ubits[i]));
        chk("enc_pm", 32'(bp8), UNIT);

        // asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step(0, 1, sym(2'($urandom_range(0, 3))));
        #2;
        rst = 0;
        #1;
        chk("arst_dv", 32'(dv8), 0);
        chk("arst_db", 32'(db8), 0);
        chk("arst_pm", 32'(bp8), 0);
        chk("arst_pm6", 32'(bp6), 0);
        chk("arst_st0", 32'(u8.pm[0]), 0);
        for (int i = 1; i < 4; i++) chk("arst_st", 32'(u8.pm[i]), 16);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;

        // frame_start with a symbol at position 30
        for (int i = 0; i < 29; i++) step(0, 1, sym(2'($urandom_range(0, 3))));
        step(1, 1, sym(2'b10));
        chk("fs_dv", 32'(dv8), 0);
        chk("fs_pm", 32'(bp8), UNIT);
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, sym(2'($urandom_range(0, 3))));
            if (dv8) nv++;
        end
        chk("fs_low_cnt", nv, 0);
        step(0, 1, sym(2'($urandom_range(0, 3))));
        chk("fs_rise", 32'(dv8), 1);

        // alternating 10/01: metrics grow until the 6-bit core normalises
        step(1, 0, sym(2'b00));
        drops = 0;
        prev = 0;
        for (int i = 0; i < 200; i++) begin
            step(0, 1, sym(i % 2 == 0 ? 2'b10 : 2'b01));
            if (int'(bp6) + 16 < prev) drops++;
            prev = int'(bp6);
        end
        chk("norm_seen", 32'(drops > 0), 1);

`ifdef ACS_SOFT_EN
        step(1, 1, {3'd0, 3'd0});
        chk("soft_pm0_zero", 32'(u8.pm[0]), 0);
        step(1, 1, {3'd7, 3'd7});
        chk("soft_pm0_seven", 32'(u8.pm[0]), 14);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
